// File: rtl/audio_pkg.sv
// Shared audio/FFT format constants and the block-sum to FFT-sample conversion.
package audio_pkg;

  localparam int AUDIO_W    = 16;
  localparam int FFT_W      = 32;
  localparam int DECIM_LOG2 = 6;
  localparam int FRAC_PAD   = 8;
  localparam int SUM_W      = AUDIO_W + DECIM_LOG2;

  // A block sum is R times the mean, so shifting by FRAC_PAD-DECIM_LOG2 yields mean * 2^FRAC_PAD exactly.
  function automatic logic signed [FFT_W-1:0] fft_format(input logic signed [SUM_W-1:0] sum);
    logic signed [FFT_W-1:0] ext;
    ext = FFT_W'(sum);
    return ext <<< (FRAC_PAD - DECIM_LOG2);
  endfunction

endpackage

// File: rtl/audio_decimator_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_decimator.sv
// Boxcar-averaging decimator: sums 2^LOG2_R codec samples and emits one FFT-format sample per block.
module audio_decimator
  import audio_pkg::*;
#(
  parameter int IN_W     = AUDIO_W,
  parameter int OUT_W    = FFT_W,
  parameter int LOG2_R   = DECIM_LOG2,
  parameter int FRAC_PAD = audio_pkg::FRAC_PAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  x_data,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [OUT_W-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [15:0]      overrun_count
);

  localparam int ACC_W = IN_W + LOG2_R;
  localparam int SHIFT = FRAC_PAD - LOG2_R;
  localparam logic [LOG2_R-1:0] IDX_LAST = {LOG2_R{1'b1}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [OUT_W-1:0] sum_ext;
  logic signed [OUT_W-1:0] result;
  logic [LOG2_R-1:0]       idx;
  logic                    block_end;
  logic                    drain;
  logic                    load;
  logic                    overrun;

  assign x_ready = 1'b1;

  // The accumulator is wide enough for R full-scale samples, so the block sum never overflows.
  always_comb begin
    sample_ext = {{LOG2_R{x_data[IN_W-1]}}, x_data};
    sum        = acc + sample_ext;
    sum_ext    = OUT_W'(sum);
    result     = sum_ext <<< SHIFT;
    block_end  = x_valid && (idx == IDX_LAST);
    drain      = y_valid && y_ready;
    load       = block_end && (!y_valid || y_ready);
    overrun    = block_end && y_valid && !y_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
    end else if (x_valid) begin
      if (block_end) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= sum;
        idx <= idx + 1'b1;
      end
    end
  end

  // A load in the same cycle as a drain keeps y_valid high, so back-to-back results never bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_data  <= '0;
      y_valid <= 1'b0;
    end else if (load) begin
      y_data  <= result;
      y_valid <= 1'b1;
    end else if (drain) begin
      y_valid <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_overrun (
    .clk  (clk),
    .reset(reset),
    .inc  (overrun),
    .count(overrun_count)
  );

endmodule

// File: tb/tb_audio_decimator.sv
// Directed self-checking bench for audio_decimator with hand-computed block results.
module tb_audio_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_data = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [31:0] y_data;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [15:0] overrun_count;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [15:0] exp_overrun = '0;

  audio_decimator dut (
    .clk          (clk),
    .reset        (reset),
    .x_data       (x_data),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .y_data       (y_data),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (y_valid && y_ready) hs_count <= hs_count + 1;
  end

  task automatic feed(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      x_data  = v;
    end
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", y_valid); end
    checks++;
    if (y_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 00000000", y_data); end
    checks++;
    if (overrun_count !== 16'h0) begin errors++; $display("FAIL reset_overrun got %0d expected 0", overrun_count); end
    checks++;
    if (x_ready !== 1'b1) begin errors++; $display("FAIL x_ready got %b expected 1", x_ready); end
  endtask

  task automatic test_block(input string name, input logic [15:0] v, input logic [31:0] exp);
    int hs0;
    hs0 = hs_count;
    y_ready = 1'b1;
    feed(v, 64);
    checks++;
    if (y_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b expected 1", name, y_valid); end
    checks++;
    if (y_data !== exp) begin errors++; $display("FAIL %s_data got %h expected %h", name, y_data, exp); end
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL %s_after got %b expected 0", name, y_valid); end
    checks++;
    if (hs_count - hs0 !== 1) begin errors++; $display("FAIL %s_handshakes got %0d expected 1", name, hs_count - hs0); end
    checks++;
    if (overrun_count !== exp_overrun) begin errors++; $display("FAIL %s_overrun got %0d expected %0d", name, overrun_count, exp_overrun); end
  endtask

  task automatic test_ramp_gaps();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      x_data  = 16'(i);
      if (i < 63) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          x_valid = 1'b0;
          x_data  = 16'hDEAD;
          y_ready = ~y_ready;
        end
        y_ready = 1'b1;
      end
    end
    @(negedge clk);
    x_valid = 1'b0;
    checks++;
    if (y_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid got %b expected 1", y_valid); end
    checks++;
    if (y_data !== 32'h00001F80) begin errors++; $display("FAIL ramp_data got %h expected 00001f80", y_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_count;
    y_ready = 1'b0;
    feed(16'd1, 64);
    checks++;
    if (y_data !== 32'h100 || y_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b expected 00000100/1", y_data, y_valid); end
    feed(16'd2, 64);
    exp_overrun++;
    checks++;
    if (y_data !== 32'h100) begin errors++; $display("FAIL bp_hold_data got %h expected 00000100", y_data); end
    checks++;
    if (overrun_count !== exp_overrun) begin errors++; $display("FAIL bp_overrun got %0d expected %0d", overrun_count, exp_overrun); end
    y_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b expected 0", y_valid); end
    checks++;
    if (hs_count - hs0 !== 1) begin errors++; $display("FAIL bp_handshakes got %0d expected 1", hs_count - hs0); end
  endtask

  task automatic test_back_to_back();
    y_ready = 1'b0;
    feed(16'd4, 64);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      x_data  = 16'd6;
      if (i == 63) y_ready = 1'b1;
    end
    @(negedge clk);
    x_valid = 1'b0;
    checks++;
    if (y_valid !== 1'b1 || y_data !== 32'h600) begin errors++; $display("FAIL b2b_load got %h/%b expected 00000600/1", y_data, y_valid); end
    checks++;
    if (overrun_count !== exp_overrun) begin errors++; $display("FAIL b2b_overrun got %0d expected %0d", overrun_count, exp_overrun); end
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b expected 0", y_valid); end
  endtask

  task automatic test_reset_partial();
    int hs0;
    y_ready = 1'b1;
    feed(16'd50, 30);
    #2 reset = 1'b1;
    #1;
    exp_overrun = '0;
    checks++;
    if (overrun_count !== 16'h0 || y_data !== 32'h0) begin errors++; $display("FAIL async_reset got %0d/%h expected 0/00000000", overrun_count, y_data); end
    #1 reset = 1'b0;
    hs0 = hs_count;
    test_block("partial", 16'd10, 32'h00000A00);
    checks++;
    if (hs_count - hs0 !== 1) begin errors++; $display("FAIL partial_total_outputs got %0d expected 1", hs_count - hs0); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_block("const100", 16'd100, 32'h00006400);
    test_block("minus1", 16'hFFFF, 32'hFFFFFF00);
    test_ramp_gaps();
    test_block("max", 16'h7FFF, 32'h007FFF00);
    test_block("min", 16'h8000, 32'hFF800000);
    test_backpressure();
    test_back_to_back();
    test_reset_partial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
